rv32i_id_fwd: RTL and testbench
===============================

Name: rv32i_id_fwd

Overview:
- Decode-stage operand-fetch block and consumer of the ex/mem/wb forwarding buses.
- Sits between ifTop and exTop. Drives register-file read addresses and selects each source operand from ex, mem, wb or the register file, in that priority.
- Detects load-use hazards and inserts bubbles, then registers the result into the exTop pipeline register.

Parameters:
- STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..3).
- XLEN, 32: datapath width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  ifTop instruction valid
- pc_in  in  32  ifTop program counter
- iw_in  in  32  ifTop instruction word
- rs1_reg_out  out  5  regfile read address 1 (combinational, iw_in[19:15])
- rs2_reg_out  out  5  regfile read address 2 (combinational, iw_in[24:20])
- rs1_data_in  in  32  regfile read data 1 (same cycle)
- rs2_data_in  in  32  regfile read data 2 (same cycle)
- df_ex_enable, df_ex_is_load  in  1 each  ex-stage writeback enable; ex instruction is a load
- df_ex_reg  in  5 / df_ex_data  in  32  ex-stage destination and result
- df_mem_enable  in  1 / df_mem_reg  in  5 / df_mem_data  in  32  mem-stage forward
- df_wb_enable  in  1 / df_wb_reg  in  5 / df_wb_data  in  32  wb-stage forward
- stall_out  out  1  to ifTop: hold pc/iw (combinational)
- valid_out, wb_en_out  out  1 each  to exTop (registered)
- pc_out, iw_out, rs1_val_out, rs2_val_out  out  32 each  to exTop (registered)
- wb_reg_out  out  5  to exTop (registered)

Behaviour:
- Reset (reset=0, async): all registered outputs 0, FSM=RUN, stall counter 0.
- Decode from iw_in[6:0]:
  - rs1 is used except for LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used only for R-type 0110011, STORE 0100011 and BRANCH 1100011.
  - wb_en = valid_in & opcode not STORE/BRANCH & rd!=0. wb_reg = iw_in[11:7].
- Forward select per operand, where rsN!=0:
  - ex hit: df_ex_enable & df_ex_reg==rsN.
  - otherwise mem hit, then wb hit, otherwise rsN_data_in.
  - rsN==0 always yields 0, never forwarded.
- Load-use hazard = valid_in & df_ex_enable & df_ex_is_load & a used rsN==df_ex_reg & rsN!=0.
- FSM RUN:
  - No hazard: register pc/iw/operands/wb_en/wb_reg and valid_out=valid_in. stall_out=0.
  - Hazard: stall_out=1; register a bubble (valid_out=0, wb_en_out=0, other registered outputs hold). Load counter with STALL_CYCLES-1. Go to STALL if STALL_CYCLES>1, otherwise remain in RUN and re-evaluate next cycle.
- FSM STALL:
  - stall_out=1 and a bubble is registered.
  - Counter decrements; at 0, return to RUN.
  - No hazard evaluation in STALL.
- Latency: 1 cycle, valid_in to valid_out.
- Back-to-back instructions without a hazard flow at 1 per cycle.
- valid_in=0: registers a bubble; no stall.
- Reset asserted mid-stall: FSM returns to RUN, stall_out=0 immediately.

Optional Feature:
- Macro RV32I_ID_FWD_STATS_EN. When defined, adds three outputs:
  - fwd_cnt_out [31:0]: operands taken from any forward bus, +1 or +2 per cycle, counted only when valid_out is registered as 1.
  - stall_cnt_out [31:0]: +1 per stall_out cycle.
  - hazard_cnt_out [15:0]: +1 per hazard detection.
- All three counters wrap at max, reset to 0, and update only when their condition is true.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then valid_in=1, iw=ADD x3,x1,x2 (0x002081B3), rs1_data_in=5, rs2_data_in=7, no forwards -> next cycle valid_out=1, rs1_val_out=5, rs2_val_out=7, wb_reg_out=3, wb_en_out=1.
- Same ADD with df_ex (x1, 0xAA), df_mem (x1, 0xBB) and df_wb (x2, 0xCC) all enabled -> rs1_val_out=0xAA, rs2_val_out=0xCC.
- ADD x3,x0,x0 with df_ex_enable=1, df_ex_reg=0, data=0xFF -> both operand outputs 0.
- df_ex_is_load=1 with df_ex_reg=1, followed by ADD using x1, STALL_CYCLES=1:
  - Stall cycle: stall_out=1 and a bubble is registered.
  - Next cycle, with df_mem x1=0x1234: rs1_val_out=0x1234 and valid_out=1.
- STALL_CYCLES=3 load-use -> stall_out high 3 cycles, 3 bubbles.
- Assert reset during the 2nd stall cycle -> outputs 0 and stall_out=0 asynchronously.
- STORE sw x2,0(x1) (0x0020A023) -> wb_en_out=0.
- Load-use hazard only on rs2 of a LUI -> no stall.

Source files
------------

// File: rtl/rv32i_id_fwd_if.sv
// Decode-stage operand bus: ifTop/regfile/forwarding inputs and the exTop pipeline outputs.
// Statistics counters appear only when RV32I_ID_FWD_STATS_EN is defined.
interface rv32i_id_fwd_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic [31:0]     pc_in;
    logic [31:0]     iw_in;
    logic [4:0]      rs1_reg_out;
    logic [4:0]      rs2_reg_out;
    logic [XLEN-1:0] rs1_data_in;
    logic [XLEN-1:0] rs2_data_in;
    logic            df_ex_enable;
    logic            df_ex_is_load;
    logic [4:0]      df_ex_reg;
    logic [XLEN-1:0] df_ex_data;
    logic            df_mem_enable;
    logic [4:0]      df_mem_reg;
    logic [XLEN-1:0] df_mem_data;
    logic            df_wb_enable;
    logic [4:0]      df_wb_reg;
    logic [XLEN-1:0] df_wb_data;
    logic            stall_out;
    logic            valid_out;
    logic            wb_en_out;
    logic [31:0]     pc_out;
    logic [31:0]     iw_out;
    logic [XLEN-1:0] rs1_val_out;
    logic [XLEN-1:0] rs2_val_out;
    logic [4:0]      wb_reg_out;
`ifdef RV32I_ID_FWD_STATS_EN
    logic [31:0]     fwd_cnt_out;
    logic [31:0]     stall_cnt_out;
    logic [15:0]     hazard_cnt_out;
`endif

    modport master (
        output valid_in, pc_in, iw_in, rs1_data_in, rs2_data_in,
               df_ex_enable, df_ex_is_load, df_ex_reg, df_ex_data,
               df_mem_enable, df_mem_reg, df_mem_data,
               df_wb_enable, df_wb_reg, df_wb_data,
        input  rs1_reg_out, rs2_reg_out, stall_out, valid_out, wb_en_out,
               pc_out, iw_out, rs1_val_out, rs2_val_out, wb_reg_out
`ifdef RV32I_ID_FWD_STATS_EN
       ,input  fwd_cnt_out, stall_cnt_out, hazard_cnt_out
`endif
    );

    modport slave (
        input  valid_in, pc_in, iw_in, rs1_data_in, rs2_data_in,
               df_ex_enable, df_ex_is_load, df_ex_reg, df_ex_data,
               df_mem_enable, df_mem_reg, df_mem_data,
               df_wb_enable, df_wb_reg, df_wb_data,
        output rs1_reg_out, rs2_reg_out, stall_out, valid_out, wb_en_out,
               pc_out, iw_out, rs1_val_out, rs2_val_out, wb_reg_out
`ifdef RV32I_ID_FWD_STATS_EN
       ,output fwd_cnt_out, stall_cnt_out, hazard_cnt_out
`endif
    );
endinterface

// File: rtl/rv32i_id_fwd.sv
// RV32I decode operand fetch: ex/mem/wb forwarding, load-use bubbles, exTop pipeline register.
// Optional forward/stall/hazard counters are enabled with RV32I_ID_FWD_STATS_EN.
module rv32i_id_fwd #(
    parameter int STALL_CYCLES = 1,
    parameter int XLEN         = 32
) (
    input logic           clk,
    input logic           reset,
    rv32i_id_fwd_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;
    localparam logic [1:0] CNT_LOAD = 2'(STALL_CYCLES - 1);

    function automatic logic bus_hit(input logic en, input logic [4:0] dst, input logic [4:0] rs);
        return en && (dst == rs) && (rs != 5'd0);
    endfunction

    // Priority ex > mem > wb > regfile; x0 is hard-wired to zero.
    function automatic logic [XLEN-1:0] fwd_val(
        input logic [4:0] rs, input logic [XLEN-1:0] rf,
        input logic ex_en, input logic [4:0] ex_rd, input logic [XLEN-1:0] ex_d,
        input logic mm_en, input logic [4:0] mm_rd, input logic [XLEN-1:0] mm_d,
        input logic wb_en, input logic [4:0] wb_rd, input logic [XLEN-1:0] wb_d);
        if (rs == 5'd0)                     return '0;
        else if (bus_hit(ex_en, ex_rd, rs)) return ex_d;
        else if (bus_hit(mm_en, mm_rd, rs)) return mm_d;
        else if (bus_hit(wb_en, wb_rd, rs)) return wb_d;
        else                                return rf;
    endfunction

    logic [0:0]      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            valid_q, wb_en_q;
    logic [31:0]     pc_q, iw_q;
    logic [XLEN-1:0] rs1_val_q, rs2_val_q;
    logic [4:0]      wb_reg_q;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            rs1_used, rs2_used, wb_en, hazard, stall, load;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign opcode   = bus.iw_in[6:0];
    assign rs1      = bus.iw_in[19:15];
    assign rs2      = bus.iw_in[24:20];
    assign rd       = bus.iw_in[11:7];
    assign rs1_used = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign wb_en    = bus.valid_in && (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != 5'd0);

    assign rs1_val = fwd_val(rs1, bus.rs1_data_in,
                             bus.df_ex_enable, bus.df_ex_reg, bus.df_ex_data,
                             bus.df_mem_enable, bus.df_mem_reg, bus.df_mem_data,
                             bus.df_wb_enable, bus.df_wb_reg, bus.df_wb_data);
    assign rs2_val = fwd_val(rs2, bus.rs2_data_in,
                             bus.df_ex_enable, bus.df_ex_reg, bus.df_ex_data,
                             bus.df_mem_enable, bus.df_mem_reg, bus.df_mem_data,
                             bus.df_wb_enable, bus.df_wb_reg, bus.df_wb_data);

    assign hazard = bus.valid_in && bus.df_ex_is_load &&
                    ((rs1_used && bus_hit(bus.df_ex_enable, bus.df_ex_reg, rs1)) ||
                     (rs2_used && bus_hit(bus.df_ex_enable, bus.df_ex_reg, rs2)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hazard) begin
                    stall = 1'b1;
                    cnt_d = CNT_LOAD;
                    if (STALL_CYCLES > 1) state_d = S_STALL;
                end else begin
                    load = 1'b1;
                end
            end
            S_STALL: begin
                stall = 1'b1;
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // Pipeline register into exTop; a bubble clears valid/wb_en and holds the rest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RUN;
            cnt_q     <= 2'd0;
            valid_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            pc_q      <= '0;
            iw_q      <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            wb_reg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                valid_q   <= bus.valid_in;
                wb_en_q   <= wb_en;
                pc_q      <= bus.pc_in;
                iw_q      <= bus.iw_in;
                rs1_val_q <= rs1_val;
                rs2_val_q <= rs2_val;
                wb_reg_q  <= rd;
            end else begin
                valid_q <= 1'b0;
                wb_en_q <= 1'b0;
            end
        end
    end

    assign bus.rs1_reg_out = rs1;
    assign bus.rs2_reg_out = rs2;
    assign bus.stall_out   = reset && stall;
    assign bus.valid_out   = valid_q;
    assign bus.wb_en_out   = wb_en_q;
    assign bus.pc_out      = pc_q;
    assign bus.iw_out      = iw_q;
    assign bus.rs1_val_out = rs1_val_q;
    assign bus.rs2_val_out = rs2_val_q;
    assign bus.wb_reg_out  = wb_reg_q;

`ifdef RV32I_ID_FWD_STATS_EN
    logic        fwd1, fwd2;
    logic [31:0] fwd_cnt_q, stall_cnt_q;
    logic [15:0] hazard_cnt_q;

    assign fwd1 = bus_hit(bus.df_ex_enable, bus.df_ex_reg, rs1) ||
                  bus_hit(bus.df_mem_enable, bus.df_mem_reg, rs1) ||
                  bus_hit(bus.df_wb_enable, bus.df_wb_reg, rs1);
    assign fwd2 = bus_hit(bus.df_ex_enable, bus.df_ex_reg, rs2) ||
                  bus_hit(bus.df_mem_enable, bus.df_mem_reg, rs2) ||
                  bus_hit(bus.df_wb_enable, bus.df_wb_reg, rs2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            hazard_cnt_q <= '0;
        end else begin
            if (load && bus.valid_in && (fwd1 || fwd2))
                fwd_cnt_q <= fwd_cnt_q + {31'd0, fwd1} + {31'd0, fwd2};
            if (stall)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((state_q == S_RUN) && hazard)
                hazard_cnt_q <= hazard_cnt_q + 16'd1;
        end
    end

    assign bus.fwd_cnt_out    = fwd_cnt_q;
    assign bus.stall_cnt_out  = stall_cnt_q;
    assign bus.hazard_cnt_out = hazard_cnt_q;
`endif
endmodule

// File: tb/tb_rv32i_id_fwd.sv
// Bench for rv32i_id_fwd: directed scenarios on STALL_CYCLES=1 and 3 builds plus a randomized model run.
module tb_rv32i_id_fwd;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        valid_in;
    logic [31:0] pc_in, iw_in, rs1_data_in, rs2_data_in;
    logic        ex_en, ex_ld, mem_en, wb_en;
    logic [4:0]  ex_reg, mem_reg, wb_reg;
    logic [31:0] ex_data, mem_data, wb_data;

    int total = 0;
    int bad   = 0;

    rv32i_id_fwd_if #(.XLEN(32)) b1 ();
    rv32i_id_fwd_if #(.XLEN(32)) b3 ();

    assign b1.valid_in = valid_in;       assign b3.valid_in = valid_in;
    assign b1.pc_in = pc_in;             assign b3.pc_in = pc_in;
    assign b1.iw_in = iw_in;             assign b3.iw_in = iw_in;
    assign b1.rs1_data_in = rs1_data_in; assign b3.rs1_data_in = rs1_data_in;
    assign b1.rs2_data_in = rs2_data_in; assign b3.rs2_data_in = rs2_data_in;
    assign b1.df_ex_enable = ex_en;      assign b3.df_ex_enable = ex_en;
    assign b1.df_ex_is_load = ex_ld;     assign b3.df_ex_is_load = ex_ld;
    assign b1.df_ex_reg = ex_reg;        assign b3.df_ex_reg = ex_reg;
    assign b1.df_ex_data = ex_data;      assign b3.df_ex_data = ex_data;
    assign b1.df_mem_enable = mem_en;    assign b3.df_mem_enable = mem_en;
    assign b1.df_mem_reg = mem_reg;      assign b3.df_mem_reg = mem_reg;
    assign b1.df_mem_data = mem_data;    assign b3.df_mem_data = mem_data;
    assign b1.df_wb_enable = wb_en;      assign b3.df_wb_enable = wb_en;
    assign b1.df_wb_reg = wb_reg;        assign b3.df_wb_reg = wb_reg;
    assign b1.df_wb_data = wb_data;      assign b3.df_wb_data = wb_data;

    rv32i_id_fwd #(.STALL_CYCLES(1), .XLEN(32)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    rv32i_id_fwd #(.STALL_CYCLES(3), .XLEN(32)) dut3 (.clk(clk), .reset(reset), .bus(b3));

    localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;

    // Expected registered outputs of the STALL_CYCLES=1 instance.
    logic        m_valid, m_wben;
    logic [31:0] m_pc, m_iw, m_v1, m_v2;
    logic [4:0]  m_wbreg;

    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'd0;
        if (ex_en && ex_reg == rs) return ex_data;
        if (mem_en && mem_reg == rs) return mem_data;
        if (wb_en && wb_reg == rs) return wb_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic [6:0] op;
        logic [4:0] r1, r2;
        logic u1, u2;
        op = iw_in[6:0];
        r1 = iw_in[19:15];
        r2 = iw_in[24:20];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return valid_in && ex_en && ex_ld &&
               ((u1 && r1 != 0 && r1 == ex_reg) || (u2 && r2 != 0 && r2 == ex_reg));
    endfunction

    task automatic model_edge();
        logic [6:0] op;
        op = iw_in[6:0];
        if (ref_hazard()) begin
            m_valid = 1'b0;
            m_wben  = 1'b0;
        end else begin
            m_valid = valid_in;
            m_pc    = pc_in;
            m_iw    = iw_in;
            m_v1    = ref_operand(iw_in[19:15], rs1_data_in);
            m_v2    = ref_operand(iw_in[24:20], rs2_data_in);
            m_wbreg = iw_in[11:7];
            m_wben  = valid_in && op != 7'h23 && op != 7'h63 && iw_in[11:7] != 5'd0;
        end
    endtask

    task automatic idle();
        valid_in = 0; pc_in = 0; iw_in = 0; rs1_data_in = 0; rs2_data_in = 0;
        ex_en = 0; ex_ld = 0; ex_reg = 0; ex_data = 0;
        mem_en = 0; mem_reg = 0; mem_data = 0;
        wb_en = 0; wb_reg = 0; wb_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        #7;
        total++;
        if ({b1.valid_out, b1.wb_en_out, b1.pc_out, b1.iw_out, b1.rs1_val_out, b1.rs2_val_out, b1.wb_reg_out, b1.stall_out} !== '0) begin
            bad++; $display("FAIL reset_dut1 got pc=%h iw=%h v=%b want all zero", b1.pc_out, b1.iw_out, b1.valid_out);
        end
        total++;
        if ({b3.valid_out, b3.wb_en_out, b3.pc_out, b3.rs1_val_out, b3.stall_out} !== '0) begin
            bad++; $display("FAIL reset_dut3 got pc=%h v=%b want all zero", b3.pc_out, b3.valid_out);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_add();
        idle();
        valid_in = 1; pc_in = 32'h100; iw_in = ADD_X3_X1_X2; rs1_data_in = 5; rs2_data_in = 7;
        #1;
        total++;
        if ({b1.rs1_reg_out, b1.rs2_reg_out, b1.stall_out} !== {5'd1, 5'd2, 1'b0}) begin
            bad++; $display("FAIL add_addr got rs1=%0d rs2=%0d stall=%b want 1 2 0", b1.rs1_reg_out, b1.rs2_reg_out, b1.stall_out);
        end
        tick();
        total++;
        if ({b1.valid_out, b1.wb_en_out, b1.wb_reg_out} !== {1'b1, 1'b1, 5'd3}) begin
            bad++; $display("FAIL add_ctrl got v=%b we=%b wr=%0d want 1 1 3", b1.valid_out, b1.wb_en_out, b1.wb_reg_out);
        end
        total++;
        if ({b1.rs1_val_out, b1.rs2_val_out, b1.pc_out} !== {32'd5, 32'd7, 32'h100}) begin
            bad++; $display("FAIL add_vals got %h %h pc=%h want 5 7 100", b1.rs1_val_out, b1.rs2_val_out, b1.pc_out);
        end
    endtask

    task automatic test_priority();
        idle();
        valid_in = 1; pc_in = 32'h104; iw_in = ADD_X3_X1_X2; rs1_data_in = 5; rs2_data_in = 7;
        ex_en = 1; ex_reg = 1; ex_data = 32'hAA;
        mem_en = 1; mem_reg = 1; mem_data = 32'hBB;
        wb_en = 1; wb_reg = 2; wb_data = 32'hCC;
        tick();
        total++;
        if ({b1.rs1_val_out, b1.rs2_val_out} !== {32'hAA, 32'hCC}) begin
            bad++; $display("FAIL fwd_priority got %h %h want aa cc", b1.rs1_val_out, b1.rs2_val_out);
        end
    endtask

    task automatic test_x0();
        idle();
        valid_in = 1; pc_in = 32'h108; iw_in = 32'h000001B3; rs1_data_in = 32'h55; rs2_data_in = 32'h66;
        ex_en = 1; ex_reg = 0; ex_data = 32'hFF;
        mem_en = 1; mem_reg = 0; mem_data = 32'hEE;
        tick();
        total++;
        if ({b1.rs1_val_out, b1.rs2_val_out, b1.valid_out} !== {32'd0, 32'd0, 1'b1}) begin
            bad++; $display("FAIL x0_zero got %h %h v=%b want 0 0 1", b1.rs1_val_out, b1.rs2_val_out, b1.valid_out);
        end
    endtask

    task automatic test_load_use1();
        idle();
        valid_in = 1; pc_in = 32'h10C; iw_in = ADD_X3_X1_X2; rs1_data_in = 5; rs2_data_in = 7;
        ex_en = 1; ex_ld = 1; ex_reg = 1; ex_data = 32'hDEAD;
        #1;
        total++;
        if ({b1.stall_out, b3.stall_out} !== 2'b11) begin
            bad++; $display("FAIL lu_stall got %b%b want 11", b1.stall_out, b3.stall_out);
        end
        tick();
        total++;
        if ({b1.valid_out, b1.wb_en_out, b1.pc_out} !== {1'b0, 1'b0, 32'h108}) begin
            bad++; $display("FAIL lu_bubble got v=%b we=%b pc=%h want 0 0 108", b1.valid_out, b1.wb_en_out, b1.pc_out);
        end
        ex_en = 0; ex_ld = 0;
        mem_en = 1; mem_reg = 1; mem_data = 32'h1234;
        #1;
        total++;
        if (b1.stall_out !== 1'b0) begin
            bad++; $display("FAIL lu_release got stall=%b want 0", b1.stall_out);
        end
        tick();
        total++;
        if ({b1.valid_out, b1.rs1_val_out, b1.pc_out} !== {1'b1, 32'h1234, 32'h10C}) begin
            bad++; $display("FAIL lu_fwd got v=%b rs1=%h pc=%h want 1 1234 10c", b1.valid_out, b1.rs1_val_out, b1.pc_out);
        end
    endtask

    task automatic test_stall3();
        idle();
        tick();
        tick();
        valid_in = 1; pc_in = 32'h200; iw_in = ADD_X3_X1_X2; rs1_data_in = 9; rs2_data_in = 8;
        ex_en = 1; ex_ld = 1; ex_reg = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (b3.stall_out !== 1'b1) begin
                bad++; $display("FAIL stall3_cyc%0d got stall=%b want 1", i, b3.stall_out);
            end
            tick();
            total++;
            if (b3.valid_out !== 1'b0) begin
                bad++; $display("FAIL stall3_bubble%0d got v=%b want 0", i, b3.valid_out);
            end
            ex_en = 0; ex_ld = 0;
        end
        #1;
        total++;
        if (b3.stall_out !== 1'b0) begin
            bad++; $display("FAIL stall3_end got stall=%b want 0", b3.stall_out);
        end
        tick();
        total++;
        if ({b3.valid_out, b3.pc_out, b3.rs1_val_out} !== {1'b1, 32'h200, 32'd9}) begin
            bad++; $display("FAIL stall3_issue got v=%b pc=%h rs1=%h want 1 200 9", b3.valid_out, b3.pc_out, b3.rs1_val_out);
        end
    endtask

    task automatic test_reset_midstall();
        idle();
        valid_in = 1; pc_in = 32'h300; iw_in = ADD_X3_X1_X2;
        ex_en = 1; ex_ld = 1; ex_reg = 2;
        tick();
        ex_en = 0; ex_ld = 0;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({b3.stall_out, b3.valid_out, b3.pc_out, b3.iw_out, b3.rs1_val_out, b3.wb_reg_out} !== '0) begin
            bad++; $display("FAIL midstall_reset got stall=%b pc=%h iw=%h want all zero", b3.stall_out, b3.pc_out, b3.iw_out);
        end
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (b3.stall_out !== 1'b0) begin
            bad++; $display("FAIL midstall_run got stall=%b want 0", b3.stall_out);
        end
        tick();
        total++;
        if ({b3.valid_out, b3.pc_out} !== {1'b1, 32'h300}) begin
            bad++; $display("FAIL midstall_issue got v=%b pc=%h want 1 300", b3.valid_out, b3.pc_out);
        end
    endtask

    task automatic test_store();
        idle();
        valid_in = 1; pc_in = 32'h400; iw_in = 32'h0020A023; rs1_data_in = 32'h11; rs2_data_in = 32'h22;
        tick();
        total++;
        if ({b1.valid_out, b1.wb_en_out, b1.rs1_val_out, b1.rs2_val_out} !== {1'b1, 1'b0, 32'h11, 32'h22}) begin
            bad++; $display("FAIL store got v=%b we=%b %h %h want 1 0 11 22", b1.valid_out, b1.wb_en_out, b1.rs1_val_out, b1.rs2_val_out);
        end
    endtask

    task automatic test_lui_rs2();
        idle();
        valid_in = 1; pc_in = 32'h500; iw_in = 32'h001002B7;
        ex_en = 1; ex_ld = 1; ex_reg = 1;
        #1;
        total++;
        if ({b1.stall_out, b3.stall_out} !== 2'b00) begin
            bad++; $display("FAIL lui_nostall got %b%b want 00", b1.stall_out, b3.stall_out);
        end
        tick();
        total++;
        if ({b1.valid_out, b1.wb_en_out, b1.wb_reg_out} !== {1'b1, 1'b1, 5'd5}) begin
            bad++; $display("FAIL lui_issue got v=%b we=%b wr=%0d want 1 1 5", b1.valid_out, b1.wb_en_out, b1.wb_reg_out);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        logic [31:0] w;
        logic exp_stall;
        ops = '{7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h03, 7'h13, 7'h67};
        idle();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_valid = 0; m_wben = 0; m_pc = 0; m_iw = 0; m_v1 = 0; m_v2 = 0; m_wbreg = 0;
        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            w[6:0]   = ops[$urandom_range(0, 8)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            iw_in = w;
            valid_in = ($urandom_range(0, 3) != 0);
            pc_in = $urandom; rs1_data_in = $urandom; rs2_data_in = $urandom;
            ex_en = 1'($urandom); ex_ld = 1'($urandom); ex_reg = 5'($urandom_range(0, 3)); ex_data = $urandom;
            mem_en = 1'($urandom); mem_reg = 5'($urandom_range(0, 3)); mem_data = $urandom;
            wb_en = 1'($urandom); wb_reg = 5'($urandom_range(0, 3)); wb_data = $urandom;
            #1;
            exp_stall = ref_hazard();
            total++;
            if ({b1.stall_out, b1.rs1_reg_out, b1.rs2_reg_out} !== {exp_stall, w[19:15], w[24:20]}) begin
                bad++; $display("FAIL rnd_comb[%0d] got stall=%b rs=%0d,%0d want %b %0d,%0d", n,
                                b1.stall_out, b1.rs1_reg_out, b1.rs2_reg_out, exp_stall, w[19:15], w[24:20]);
            end
            model_edge();
            tick();
            total++;
            if ({b1.valid_out, b1.wb_en_out, b1.wb_reg_out, b1.pc_out, b1.iw_out, b1.rs1_val_out, b1.rs2_val_out} !==
                {m_valid, m_wben, m_wbreg, m_pc, m_iw, m_v1, m_v2}) begin
                bad++; $display("FAIL rnd_reg[%0d] got v=%b we=%b wr=%0d pc=%h iw=%h %h %h want v=%b we=%b wr=%0d pc=%h iw=%h %h %h", n,
                                b1.valid_out, b1.wb_en_out, b1.wb_reg_out, b1.pc_out, b1.iw_out, b1.rs1_val_out, b1.rs2_val_out,
                                m_valid, m_wben, m_wbreg, m_pc, m_iw, m_v1, m_v2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_add();
        test_priority();
        test_x0();
        test_load_use1();
        test_stall3();
        test_reset_midstall();
        test_store();
        test_lui_rs2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
